// File: rtl/lamp_seq_ctrl_pkg.sv
// Shared definitions for the stairway lamp sequencing controller.
package lamp_pkg;

  // Default width of the timer and debounce counters
  localparam int LAMP_TW = 28;

  // Width of the status LED bus
  localparam int LED_W = 7;

  // LED bit positions (all LEDs are active-low)
  localparam int LED_ON_BIT   = 3;
  localparam int LED_WARN_BIT = 4;

  // Controller state encoding; 2'd3 is unused and falls back to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    WARN = 2'd2
  } state_t;

endpackage

// File: rtl/lamp_seq_ctrl_if.sv
// Board-side signal bundle: three raw wall switches in, lamp/buzzer/LED drives out.
interface lamp_seq_ctrl_if;
  import lamp_pkg::*;

  logic             S1;
  logic             S2;
  logic             S3;
  logic             F;
  logic             Buzzer;
  logic [LED_W-1:0] LED;

  // Board / stimulus side drives the switches and observes the drives
  modport master (output S1, S2, S3, input F, Buzzer, LED);

  // Controller side
  modport slave (input S1, S2, S3, output F, Buzzer, LED);

endinterface

// File: rtl/lamp_seq_ctrl_debounce.sv
// One wall switch: 2-FF synchronizer followed by a stable-for-N-cycles debouncer.
module switch_debounce
  import lamp_pkg::*;
#(
  parameter int              TW        = LAMP_TW,
  parameter longint unsigned DB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam logic [TW-1:0] DB_LAST = TW'(DB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic [TW-1:0] r_cnt;

  // Bring the raw asynchronous switch into the clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has differed from the current one for DB_CYCLES samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else if (r_sync2 == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == DB_LAST) begin
      r_db  <= r_sync2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  assign dout = r_db;

endmodule

// File: rtl/lamp_seq_ctrl.sv
// Stairway lamp timer: parity-toggle retrigger, IDLE/ON/WARN sequencing, blink and buzzer.
module lamp_seq_ctrl
  import lamp_pkg::*;
#(
  parameter int              TW          = LAMP_TW,
  parameter longint unsigned DB_CYCLES   = 500_000,
  parameter longint unsigned ON_CYCLES   = 28'hFFF_FFFF,
  parameter longint unsigned WARN_CYCLES = 50_000_000,
  parameter longint unsigned BLINK_HALF  = 6_250_000
) (
  input  logic            clk,
  input  logic            rst,
  lamp_seq_ctrl_if.slave  bus
);

  localparam longint unsigned MAX_VAL = (64'd1 << TW) - 64'd1;

  localparam logic [TW-1:0] ON_LAST    = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] WARN_LAST  = TW'(WARN_CYCLES - 1);
  localparam logic [TW-1:0] BLINK_LAST = TW'(BLINK_HALF - 1);
  // One extra bit so DB_CYCLES+2 never wraps
  localparam logic [TW:0]   PRIME_AT   = (TW+1)'(DB_CYCLES + 2);

  // Reject parameter sets that do not fit the counters or cannot blink a full period
  generate
    if (DB_CYCLES < 2 || DB_CYCLES > MAX_VAL) begin : g_bad_db
      $error("lamp_seq_ctrl: DB_CYCLES out of range");
    end
    if (ON_CYCLES < 1 || ON_CYCLES > MAX_VAL) begin : g_bad_on
      $error("lamp_seq_ctrl: ON_CYCLES out of range");
    end
    if (BLINK_HALF < 1 || WARN_CYCLES < 2 * BLINK_HALF || WARN_CYCLES > MAX_VAL) begin : g_bad_warn
      $error("lamp_seq_ctrl: WARN_CYCLES/BLINK_HALF out of range");
    end
  endgenerate

  logic [2:0]       w_sw;
  logic [2:0]       w_db;
  logic             w_par;
  logic             w_tog;
  logic             r_par_d;
  logic [TW:0]      r_pcnt;
  logic             r_primed;

  state_t           r_state;
  state_t           w_state_next;
  logic [TW-1:0]    r_timer;
  logic [TW-1:0]    w_timer_next;
  logic [TW-1:0]    r_bcnt;
  logic [TW-1:0]    w_bcnt_next;
  logic             r_phase;
  logic             w_phase_next;

  logic             w_f;
  logic             w_buzzer;
  logic [LED_W-1:0] w_led;

  assign w_sw = {bus.S3, bus.S2, bus.S1};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sw
      switch_debounce #(
        .TW        (TW),
        .DB_CYCLES (DB_CYCLES)
      ) u_db (
        .clk  (clk),
        .rst  (rst),
        .din  (w_sw[gi]),
        .dout (w_db[gi])
      );
    end
  endgenerate

  // Any single switch flip changes the parity; a simultaneous pair cancels out
  assign w_par = ^w_db;
  assign w_tog = r_primed & (w_par ^ r_par_d);

  // Parity history and power-up priming: hold off events until the debouncers have settled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_d  <= 1'b0;
      r_pcnt   <= '0;
      r_primed <= 1'b0;
    end else begin
      r_par_d <= w_par;
      if (!r_primed) begin
        if (r_pcnt == PRIME_AT) begin
          r_primed <= 1'b1;
        end else begin
          r_pcnt <= r_pcnt + (TW+1)'(1);
        end
      end
    end
  end

  // FSM state, timer and blink registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      r_bcnt  <= w_bcnt_next;
      r_phase <= w_phase_next;
    end
  end

  // Next-state logic; a retrigger always beats an expiring timer
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_bcnt_next  = r_bcnt;
    w_phase_next = r_phase;
    case (r_state)
      IDLE: begin
        w_timer_next = '0;
        w_bcnt_next  = '0;
        w_phase_next = 1'b0;
        if (w_tog) w_state_next = ON;
      end
      ON: begin
        if (w_tog) begin
          w_timer_next = '0;
        end else if (r_timer == ON_LAST) begin
          w_state_next = WARN;
          w_timer_next = '0;
          w_bcnt_next  = '0;
          w_phase_next = 1'b0;
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      WARN: begin
        if (w_tog) begin
          w_state_next = ON;
          w_timer_next = '0;
          w_bcnt_next  = '0;
          w_phase_next = 1'b0;
        end else if (r_timer == WARN_LAST) begin
          w_state_next = IDLE;
          w_timer_next = '0;
          w_bcnt_next  = '0;
          w_phase_next = 1'b0;
        end else begin
          w_timer_next = r_timer + TW'(1);
          if (r_bcnt == BLINK_LAST) begin
            w_bcnt_next  = '0;
            w_phase_next = ~r_phase;
          end else begin
            w_bcnt_next = r_bcnt + TW'(1);
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_timer_next = '0;
        w_bcnt_next  = '0;
        w_phase_next = 1'b0;
      end
    endcase
  end

  // Active-low drives decoded from the registered state; lamp dark half of WARN sounds the buzzer
  always_comb begin
    w_f      = 1'b1;
    w_buzzer = 1'b1;
    w_led    = '1;
    w_led[2:0] = ~w_db;
    case (r_state)
      ON: begin
        w_f               = 1'b0;
        w_led[LED_ON_BIT] = 1'b0;
      end
      WARN: begin
        w_f                 = r_phase;
        w_buzzer            = ~r_phase;
        w_led[LED_WARN_BIT] = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.F      = w_f;
  assign bus.Buzzer = w_buzzer;
  assign bus.LED    = w_led;

endmodule
